iob2axi_rd_burst: RTL and testbench

//  Native-to-AXI4 read bridge for multi-burst transfers. A control request (start address, total beat count)
//  is split into consecutive INCR bursts of at most MAX_BURST_LEN beats, one outstanding at a time.

---
 rtl/iob2axi_rd_burst.sv | 152 +++++++++++++++
 tb/tb_iob2axi_rd_burst.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob2axi_rd_burst.sv
// Native-to-AXI4 read bridge: splits a (start addr, beat count) request into INCR bursts, one outstanding.
// Optional macro IOB2AXI_RD_4K_SPLIT_EN additionally bounds each burst so it never crosses a 4 KB page.
module iob2axi_rd_burst #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TRANS_LEN_W   = 16,
  parameter int MAX_BURST_LEN = 256,
  parameter int AXI_ID_W      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [TRANS_LEN_W-1:0] length,
  output logic                   ready,
  output logic                   error,
  input  logic                   s_valid,
  output logic [DATA_W-1:0]      s_rdata,
  output logic                   s_ready,
  output logic [AXI_ID_W-1:0]    m_axi_arid,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [3:0]             m_axi_arcache,
  output logic [2:0]             m_axi_arprot,
  output logic [3:0]             m_axi_arqos,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [AXI_ID_W-1:0]    m_axi_rid,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);
  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]      r_cur_addr;
  logic [TRANS_LEN_W-1:0] r_remaining;
  logic [8:0]             r_beat_cnt;
  logic                   r_error;
  logic [DATA_W-1:0]      r_s_rdata;
  logic                   r_s_ready;

  logic [8:0]             w_blen;
  logic                   w_beat;
  logic                   w_last;
  logic [TRANS_LEN_W-1:0] w_rem_nxt;
  logic [ADDR_W-1:0]      w_addr_inc;
  logic                   w_unused;

  assign w_unused = ^m_axi_rid;

`ifdef IOB2AXI_RD_4K_SPLIT_EN
  logic [12:0] w_to4k;
  assign w_to4k = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> SIZE;
`endif

  // cur_addr/remaining stay constant for the whole burst, so blen is stable in ADDR and DATA
  always_comb begin
    w_blen = (32'(r_remaining) > MAX_BURST_LEN) ? 9'(MAX_BURST_LEN) : 9'(r_remaining);
`ifdef IOB2AXI_RD_4K_SPLIT_EN
    if (32'(w_to4k) < 32'(w_blen)) w_blen = 9'(w_to4k);
`endif
  end

  assign w_beat     = m_axi_rvalid & m_axi_rready;
  assign w_last     = (r_beat_cnt == w_blen - 9'd1);
  assign w_rem_nxt  = r_remaining - TRANS_LEN_W'(w_blen);
  assign w_addr_inc = ADDR_W'(w_blen) << SIZE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    ready         = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (run && length != '0) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        m_axi_rready = s_valid;
        if (w_beat && w_last) w_state_nxt = (w_rem_nxt != '0) ? S_ADDR : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_error     <= 1'b0;
      r_s_rdata   <= '0;
      r_s_ready   <= 1'b0;
    end else begin
      r_s_rdata <= m_axi_rdata;
      r_s_ready <= w_beat;
      case (r_state)
        S_IDLE: if (run) begin
          r_error <= 1'b0;
          if (length != '0) begin
            r_cur_addr  <= addr;
            r_remaining <= length;
          end
        end
        S_ADDR: if (m_axi_arready) r_beat_cnt <= '0;
        S_DATA: if (w_beat) begin
          // bad response or misplaced rlast is flagged but the burst still runs to its count
          if (m_axi_rresp != 2'b00 || m_axi_rlast != w_last) r_error <= 1'b1;
          if (w_last) begin
            r_remaining <= w_rem_nxt;
            r_cur_addr  <= r_cur_addr + w_addr_inc;
          end else begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign error         = r_error;
  assign s_rdata       = r_s_rdata;
  assign s_ready       = r_s_ready;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_cur_addr;
  assign m_axi_arlen   = 8'(w_blen - 9'd1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'b0000;
endmodule

// File: tb/tb_iob2axi_rd_burst.sv
// Bench for iob2axi_rd_burst: cycle vector table for short transfers, plus a small AXI slave model
// for multi-burst, s_valid throttling and mid-transfer reset sequences.
module tb_iob2axi_rd_burst;
  logic        clk, rst, run;
  logic [31:0] addr;
  logic [15:0] length;
  logic        ready, error, s_valid, s_ready;
  logic [31:0] s_rdata;
  logic [0:0]  m_axi_arid, m_axi_rid;
  logic [31:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]  m_axi_arcache, m_axi_arqos;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  iob2axi_rd_burst dut (
    .clk(clk), .rst(rst), .run(run), .addr(addr), .length(length),
    .ready(ready), .error(error), .s_valid(s_valid), .s_rdata(s_rdata), .s_ready(s_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [31:0] a;
    logic [15:0] l;
    logic        sv, arr, rv;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rl;
    logic        e_rdy, e_arv;
    logic [31:0] e_araddr;
    logic [7:0]  e_arlen;
    logic        e_rrdy, e_sr;
    logic [31:0] e_srd;
    logic        e_err;
  } vec_t;

  vec_t tbl[26];
  int   total = 0;
  int   bad   = 0;
  int   ar_a_q[$];
  int   ar_l_q[$];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [15:0] l,
                              input logic sv, input logic arr, input logic rv, input logic [31:0] rd,
                              input logic [1:0] rr, input logic rl, input logic e_rdy, input logic e_arv,
                              input logic [31:0] e_araddr, input logic [7:0] e_arlen, input logic e_rrdy,
                              input logic e_sr, input logic [31:0] e_srd, input logic e_err);
    vec_t v;
    v.run = r; v.a = a; v.l = l; v.sv = sv; v.arr = arr; v.rv = rv; v.rd = rd; v.rr = rr; v.rl = rl;
    v.e_rdy = e_rdy; v.e_arv = e_arv; v.e_araddr = e_araddr; v.e_arlen = e_arlen;
    v.e_rrdy = e_rrdy; v.e_sr = e_sr; v.e_srd = e_srd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // responsive slave: arready=1, data word = D0000000 + global beat index, rresp OKAY, correct rlast
  task automatic do_xfer(input logic [31:0] a, input logic [15:0] n, input bit tog);
    int rx, gb, bi, blm1, cyc;
    bit act, done;
    ar_a_q.delete(); ar_l_q.delete();
    @(posedge clk); #1;
    run = 1'b1; addr = a; length = n; s_valid = 1'b0; m_axi_arready = 1'b1; m_axi_rvalid = 1'b0;
    @(negedge clk);
    chk("xfer start ready", 32'(ready), 32'd1);
    rx = 0; gb = 0; bi = 0; blm1 = 0; act = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      run          = 1'b0;
      s_valid      = tog ? ~s_valid : 1'b1;
      m_axi_rvalid = act;
      m_axi_rdata  = 32'hD000_0000 + 32'(gb);
      m_axi_rresp  = 2'b00;
      m_axi_rlast  = act && (bi == blm1);
      @(negedge clk);
      cyc++;
      if (s_ready) begin
        chk("xfer data", s_rdata, 32'hD000_0000 + 32'(rx));
        rx++;
      end
      if (act) begin
        chk("xfer rready", 32'(m_axi_rready), 32'(s_valid));
        if (s_valid) begin
          gb++;
          if (bi == blm1) act = 1'b0;
          else bi++;
        end
      end else if (m_axi_arvalid) begin
        ar_a_q.push_back(int'(m_axi_araddr));
        ar_l_q.push_back(int'(m_axi_arlen));
        act = 1'b1; bi = 0; blm1 = int'(m_axi_arlen);
      end
      if (ready && rx == int'(n) && !act) done = 1'b1;
    end
    chk("xfer completed", 32'(done), 32'd1);
    chk("xfer beat count", 32'(rx), 32'(n));
    chk("xfer error", 32'(error), 32'd0);
    s_valid = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  task automatic chk_ar(input string nm, input int idx, input logic [31:0] ea, input int el);
    if (ar_a_q.size() > idx) begin
      chk({nm, " araddr"}, 32'(ar_a_q[idx]), ea);
      chk({nm, " arlen"}, 32'(ar_l_q[idx]), 32'(el));
    end else begin
      chk({nm, " burst present"}, 32'(ar_a_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // test 1: 4 beats at 0x0, with a run on the final beat that must be ignored
    tbl[0]  = mk(1, 32'h0,   4, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);
    tbl[1]  = mk(0, 32'h0,   0, 0,1,0, 32'h0,        0,0, 0,1,32'h0,  8'd3, 0,0,32'h0,        0);
    tbl[2]  = mk(0, 32'h0,   0, 1,0,1, 32'h1111_0000,0,0, 0,0,32'h0,  8'd0, 1,0,32'h0,        0);
    tbl[3]  = mk(0, 32'h0,   0, 1,0,1, 32'h1111_0001,0,0, 0,0,32'h0,  8'd0, 1,1,32'h1111_0000,0);
    tbl[4]  = mk(0, 32'h0,   0, 1,0,1, 32'h1111_0002,0,0, 0,0,32'h0,  8'd0, 1,1,32'h1111_0001,0);
    tbl[5]  = mk(1, 32'h40,  5, 1,0,1, 32'h1111_0003,0,1, 0,0,32'h0,  8'd0, 1,1,32'h1111_0002,0);
    tbl[6]  = mk(0, 32'h0,   0, 1,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,1,32'h1111_0003,0);
    tbl[7]  = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);
    // test 4: arready delayed, s_valid stall, rresp=SLVERR on beat 2
    tbl[8]  = mk(1, 32'h80,  4, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);
    tbl[9]  = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 0,1,32'h80, 8'd3, 0,0,32'h0,        0);
    tbl[10] = mk(0, 32'h0,   0, 0,1,0, 32'h0,        0,0, 0,1,32'h80, 8'd3, 0,0,32'h0,        0);
    tbl[11] = mk(0, 32'h0,   0, 1,0,1, 32'h2222_0000,0,0, 0,0,32'h0,  8'd0, 1,0,32'h0,        0);
    tbl[12] = mk(0, 32'h0,   0, 0,0,1, 32'h2222_0001,0,0, 0,0,32'h0,  8'd0, 0,1,32'h2222_0000,0);
    tbl[13] = mk(0, 32'h0,   0, 1,0,1, 32'h2222_0001,0,0, 0,0,32'h0,  8'd0, 1,0,32'h0,        0);
    tbl[14] = mk(0, 32'h0,   0, 1,0,1, 32'h2222_0002,2,0, 0,0,32'h0,  8'd0, 1,1,32'h2222_0001,0);
    tbl[15] = mk(0, 32'h0,   0, 1,0,1, 32'h2222_0003,0,1, 0,0,32'h0,  8'd0, 1,1,32'h2222_0002,1);
    tbl[16] = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,1,32'h2222_0003,1);
    tbl[17] = mk(1, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        1);
    tbl[18] = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);
    // early rlast on beat 0 of 2 raises error; length=0 run clears it without AXI activity
    tbl[19] = mk(1, 32'h200, 2, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);
    tbl[20] = mk(0, 32'h0,   0, 0,1,0, 32'h0,        0,0, 0,1,32'h200,8'd1, 0,0,32'h0,        0);
    tbl[21] = mk(0, 32'h0,   0, 1,0,1, 32'h3333_0000,0,1, 0,0,32'h0,  8'd0, 1,0,32'h0,        0);
    tbl[22] = mk(0, 32'h0,   0, 1,0,1, 32'h3333_0001,0,1, 0,0,32'h0,  8'd0, 1,1,32'h3333_0000,1);
    tbl[23] = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,1,32'h3333_0001,1);
    tbl[24] = mk(1, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        1);
    tbl[25] = mk(0, 32'h0,   0, 0,0,0, 32'h0,        0,0, 1,0,32'h0,  8'd0, 0,0,32'h0,        0);

    rst = 1'b1; run = 1'b0; addr = '0; length = '0; s_valid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready",   32'(ready), 32'd1);
    chk("reset arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("reset rready",  32'(m_axi_rready), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset s_rdata", s_rdata, 32'd0);
    chk("reset error",   32'(error), 32'd0);
    chk("static ar",     {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
                          m_axi_arqos, m_axi_arid}, {3'd2, 2'd1, 1'b0, 4'd2, 3'd2, 4'd0, 1'b0});
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      run = tbl[i].run; addr = tbl[i].a; length = tbl[i].l; s_valid = tbl[i].sv;
      m_axi_arready = tbl[i].arr; m_axi_rvalid = tbl[i].rv; m_axi_rdata = tbl[i].rd;
      m_axi_rresp = tbl[i].rr; m_axi_rlast = tbl[i].rl;
      @(negedge clk);
      chk($sformatf("v%0d ready", i),   32'(ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d arvalid", i), 32'(m_axi_arvalid), 32'(tbl[i].e_arv));
      chk($sformatf("v%0d rready", i),  32'(m_axi_rready), 32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
      chk($sformatf("v%0d error", i),   32'(error), 32'(tbl[i].e_err));
      if (tbl[i].e_arv) begin
        chk($sformatf("v%0d araddr", i), m_axi_araddr, tbl[i].e_araddr);
        chk($sformatf("v%0d arlen", i),  32'(m_axi_arlen), 32'(tbl[i].e_arlen));
      end
      if (tbl[i].e_sr) chk($sformatf("v%0d s_rdata", i), s_rdata, tbl[i].e_srd);
    end

    // test 2: 600 beats split 256/256/88
    do_xfer(32'h100, 16'd600, 1'b0);
    chk("t2 bursts", 32'(ar_a_q.size()), 32'd3);
    chk_ar("t2 b0", 0, 32'h100, 255);
    chk_ar("t2 b1", 1, 32'h500, 255);
    chk_ar("t2 b2", 2, 32'h900, 87);

    // test 3: 8 beats straddling the 0x1000 page
    do_xfer(32'hFF0, 16'd8, 1'b0);
`ifdef IOB2AXI_RD_4K_SPLIT_EN
    chk("t3 bursts", 32'(ar_a_q.size()), 32'd2);
    chk_ar("t3 b0", 0, 32'hFF0, 3);
    chk_ar("t3 b1", 1, 32'h1000, 3);
`else
    chk("t3 bursts", 32'(ar_a_q.size()), 32'd1);
    chk_ar("t3 b0", 0, 32'hFF0, 7);
`endif

    // test 5: s_valid toggling every cycle
    do_xfer(32'h3000, 16'd10, 1'b1);
    chk("t5 bursts", 32'(ar_a_q.size()), 32'd1);
    chk_ar("t5 b0", 0, 32'h3000, 9);

    // test 6: reset in the middle of a data phase, then a clean transfer
    @(posedge clk); #1; run = 1'b1; addr = 32'h40; length = 16'd4; m_axi_arready = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    @(posedge clk); #1; m_axi_arready = 1'b0; s_valid = 1'b1; m_axi_rvalid = 1'b1;
    m_axi_rdata = 32'h4444_0000; m_axi_rlast = 1'b0;
    @(negedge clk);
    chk("t6 data rready", 32'(m_axi_rready), 32'd1);
    chk("t6 busy", 32'(ready), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t6 still busy", 32'(ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0; s_valid = 1'b0; m_axi_rvalid = 1'b0;
    @(negedge clk);
    chk("t6 rst ready",   32'(ready), 32'd1);
    chk("t6 rst arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("t6 rst s_ready", 32'(s_ready), 32'd0);
    chk("t6 rst rready",  32'(m_axi_rready), 32'd0);
    do_xfer(32'h0, 16'd3, 1'b0);
    chk("t6 recover bursts", 32'(ar_a_q.size()), 32'd1);
    chk_ar("t6 recover", 0, 32'h0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
